// File: rtl/ula_port_int.sv
// ULA interrupt/port companion: frame interrupt from vsync, port 0xFE write latch,
// frame counter with FLASH phase, and a synchronised tape input for port 0xFE reads.
module ula_port_int #(
    parameter int INT_LEN    = 32,
    parameter bit VS_ACT_LOW = 1'b1,
    parameter int FLASH_BIT  = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cpu_tick,
    input  logic       vsync,
    input  logic       n_ioWR,
    input  logic       cpu_addr0,
    input  logic [7:0] cpu_dout,
    input  logic       tape_in,
    output logic       int_n,
    output logic [2:0] border,
    output logic       mic,
    output logic       ear,
    output logic [1:0] audio,
    output logic       flash,
    output logic       ear_in,
    output logic [4:0] frame_cnt
);

    localparam int TW = (INT_LEN > 1) ? $clog2(INT_LEN) : 1;
    localparam logic [TW-1:0] TCNT_LAST = TW'(INT_LEN - 1);

    typedef enum logic {
        IDLE,
        ASSERT
    } state_t;

    state_t        state, next_state;
    logic [TW-1:0] tcnt, tcnt_next;

    logic vs_meta, vs_sync, vs_prev, frame_start;
    logic wr_cur, wr_prev, wr_fall;
    logic tape_meta;
    logic unused_dout_bits;

    assign unused_dout_bits = ^cpu_dout[7:5];

    // Vsync: two-flop synchroniser, delay flop, then a registered active-edge pulse.
    // NOTE: every clocked register uses non-blocking (<=) so all flops sample
    // pre-edge values; blocking here would collapse the synchroniser chain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vs_meta     <= 1'b0;
            vs_sync     <= 1'b0;
            vs_prev     <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            vs_meta     <= vsync;
            vs_sync     <= vs_meta;
            vs_prev     <= vs_sync;
            frame_start <= VS_ACT_LOW ? (vs_prev & ~vs_sync) : (~vs_prev & vs_sync);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            tcnt  <= '0;
        end else begin
            state <= next_state;
            tcnt  <= tcnt_next;
        end
    end

    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    always_comb begin
        next_state = state;
        tcnt_next  = tcnt;
        case (state)
            IDLE: begin
                if (frame_start) begin
                    next_state = ASSERT;
                    tcnt_next  = '0;
                end
            end
            ASSERT: begin
                // A frame_start here is deliberately ignored: the pulse is never stretched.
                if (cpu_tick) begin
                    if (tcnt == TCNT_LAST) begin
                        next_state = IDLE;
                    end else begin
                        tcnt_next = tcnt + 1'b1;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign int_n = (state != ASSERT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_cnt <= '0;
        end else if (frame_start) begin
            frame_cnt <= frame_cnt + 5'd1;
        end
    end

    assign flash = frame_cnt[FLASH_BIT];

    // Strobe is registered twice so the falling edge is seen once per write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_cur  <= 1'b1;
            wr_prev <= 1'b1;
        end else begin
            wr_cur  <= n_ioWR;
            wr_prev <= wr_cur;
        end
    end

    assign wr_fall = wr_prev & ~wr_cur;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            border <= 3'b000;
            mic    <= 1'b0;
            ear    <= 1'b0;
            audio  <= 2'b00;
        end else if (wr_fall && !cpu_addr0) begin
            border <= cpu_dout[2:0];
            mic    <= cpu_dout[3];
            ear    <= cpu_dout[4];
            audio  <= {cpu_dout[4], cpu_dout[3]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tape_meta <= 1'b0;
            ear_in    <= 1'b0;
        end else begin
            tape_meta <= tape_in;
            ear_in    <= tape_meta;
        end
    end

endmodule

// File: tb/tb_ula_port_int.sv
// Directed bench for ula_port_int: frame interrupt timing, retrigger/coincidence,
// port 0xFE writes, tape synchroniser and the 32-frame flash cycle.
module tb_ula_port_int;

    logic       clk = 1'b0;
    logic       reset;
    logic       cpu_tick;
    logic       vsync;
    logic       n_ioWR;
    logic       cpu_addr0;
    logic [7:0] cpu_dout;
    logic       tape_in;
    logic       int_n;
    logic [2:0] border;
    logic       mic;
    logic       ear;
    logic [1:0] audio;
    logic       flash;
    logic       ear_in;
    logic [4:0] frame_cnt;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int tdiv      = 0;
    bit tick_on   = 1'b1;
    int low_clks  = 0;
    int low_ticks = 0;

    ula_port_int dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_tick  (cpu_tick),
        .vsync     (vsync),
        .n_ioWR    (n_ioWR),
        .cpu_addr0 (cpu_addr0),
        .cpu_dout  (cpu_dout),
        .tape_in   (tape_in),
        .int_n     (int_n),
        .border    (border),
        .mic       (mic),
        .ear       (ear),
        .audio     (audio),
        .flash     (flash),
        .ear_in    (ear_in),
        .frame_cnt (frame_cnt)
    );

    always #20 clk = ~clk;

    // One clock: drive cpu_tick (every 5th clk) after the edge, observe int_n mid-cycle.
    task automatic cycle();
        @(posedge clk);
        #2;
        tdiv     = (tdiv == 4) ? 0 : tdiv + 1;
        cpu_tick = tick_on && (tdiv == 0);
        @(negedge clk);
        if (int_n === 1'b0) begin
            low_clks++;
            if (cpu_tick) low_ticks++;
        end
    endtask

    task automatic test_reset();
        logic [14:0] snap;
        #1;
        snap = {int_n, border, mic, ear, audio, flash, ear_in, frame_cnt};
        total_cnt++;
        if (snap !== 15'h4000) $display("FAIL reset_values got=%h exp=%h", snap, 15'h4000);
        else pass_cnt++;
        @(negedge clk);
        reset = 1'b0;
        repeat (4) cycle();
        vsync = 1'b0;
        tdiv  = 2;
        repeat (6) cycle();
        total_cnt++;
        if (int_n !== 1'b0) $display("FAIL reset_pre_assert int_n got=%b exp=0", int_n);
        else pass_cnt++;
        #5;
        reset = 1'b1;
        #1;
        total_cnt++;
        if ({int_n, border, frame_cnt} !== {1'b1, 3'b000, 5'd0})
            $display("FAIL reset_mid_assert got int_n=%b border=%b frame_cnt=%0d exp 1/000/0",
                     int_n, border, frame_cnt);
        else pass_cnt++;
        vsync = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (6) cycle();
        total_cnt++;
        if ({int_n, frame_cnt} !== {1'b1, 5'd0})
            $display("FAIL reset_release got int_n=%b frame_cnt=%0d exp 1/0", int_n, frame_cnt);
        else pass_cnt++;
    endtask

    task automatic test_int_pulse();
        low_clks  = 0;
        low_ticks = 0;
        vsync     = 1'b0;
        tdiv      = 2;
        for (int k = 1; k <= 300; k++) begin
            cycle();
            if (k == 3) begin
                total_cnt++;
                if (int_n !== 1'b1) $display("FAIL int_latency_early int_n got=%b exp=1", int_n);
                else pass_cnt++;
            end
            if (k == 4) begin
                total_cnt++;
                if (int_n !== 1'b0) $display("FAIL int_latency_fall int_n got=%b exp=0", int_n);
                else pass_cnt++;
            end
            if (k == 6) vsync = 1'b1;
            if (k > 4 && int_n === 1'b1) break;
        end
        total_cnt++;
        if (low_ticks != 32) $display("FAIL int_len_ticks got=%0d exp=32", low_ticks);
        else pass_cnt++;
        total_cnt++;
        if (low_clks != 160) $display("FAIL int_len_clks got=%0d exp=160", low_clks);
        else pass_cnt++;
        total_cnt++;
        if (frame_cnt !== 5'd1) $display("FAIL int_frame_cnt got=%0d exp=1", frame_cnt);
        else pass_cnt++;
    endtask

    task automatic test_retrigger();
        bit fired = 1'b0;
        int rel   = 0;
        low_clks  = 0;
        low_ticks = 0;
        vsync     = 1'b0;
        tdiv      = 2;
        for (int k = 1; k <= 300; k++) begin
            cycle();
            if (k == 6) vsync = 1'b1;
            if (!fired && low_ticks == 10) begin
                vsync = 1'b0;
                fired = 1'b1;
                rel   = k + 6;
            end
            if (fired && k == rel) vsync = 1'b1;
            if (k > 4 && int_n === 1'b1) break;
        end
        total_cnt++;
        if (low_ticks != 32) $display("FAIL retrigger_ticks got=%0d exp=32", low_ticks);
        else pass_cnt++;
        total_cnt++;
        if (low_clks != 160) $display("FAIL retrigger_clks got=%0d exp=160", low_clks);
        else pass_cnt++;
        total_cnt++;
        if (frame_cnt !== 5'd3) $display("FAIL retrigger_frame_cnt got=%0d exp=3", frame_cnt);
        else pass_cnt++;
    endtask

    // Second frame_start lands on the same clk as the 32nd tick: the frame is dropped.
    task automatic test_coincident();
        low_clks  = 0;
        low_ticks = 0;
        vsync     = 1'b0;
        tdiv      = 2;
        for (int k = 1; k <= 176; k++) begin
            cycle();
            if (k == 6) vsync = 1'b1;
            if (k == 160) vsync = 1'b0;
            if (k == 166) vsync = 1'b1;
        end
        total_cnt++;
        if (low_clks != 160 || low_ticks != 32)
            $display("FAIL coincident_len got clks=%0d ticks=%0d exp 160/32", low_clks, low_ticks);
        else pass_cnt++;
        total_cnt++;
        if (int_n !== 1'b1) $display("FAIL coincident_idle int_n got=%b exp=1", int_n);
        else pass_cnt++;
        total_cnt++;
        if (frame_cnt !== 5'd5) $display("FAIL coincident_frame_cnt got=%0d exp=5", frame_cnt);
        else pass_cnt++;
    endtask

    task automatic test_port_write();
        cpu_addr0 = 1'b0;
        cpu_dout  = 8'h1D;
        n_ioWR    = 1'b0;
        cycle();
        total_cnt++;
        if (border !== 3'b000) $display("FAIL write_1clk border got=%b exp=000", border);
        else pass_cnt++;
        cycle();
        total_cnt++;
        if ({border, mic, ear, audio} !== {3'b101, 1'b1, 1'b1, 2'b11})
            $display("FAIL write_1d got border=%b mic=%b ear=%b audio=%b exp 101/1/1/11",
                     border, mic, ear, audio);
        else pass_cnt++;
        cpu_dout = 8'h02;
        repeat (3) cycle();
        total_cnt++;
        if (border !== 3'b101) $display("FAIL write_held_low border got=%b exp=101", border);
        else pass_cnt++;
        n_ioWR = 1'b1;
        repeat (2) cycle();
        cpu_addr0 = 1'b1;
        n_ioWR    = 1'b0;
        repeat (3) cycle();
        n_ioWR = 1'b1;
        repeat (2) cycle();
        total_cnt++;
        if ({border, audio} !== {3'b101, 2'b11})
            $display("FAIL write_addr0_ignored got border=%b audio=%b exp 101/11", border, audio);
        else pass_cnt++;
        cpu_addr0 = 1'b0;
        cpu_dout  = 8'h0A;
        n_ioWR    = 1'b0;
        repeat (2) cycle();
        n_ioWR = 1'b1;
        total_cnt++;
        if ({border, mic, ear, audio} !== {3'b010, 1'b1, 1'b0, 2'b01})
            $display("FAIL write_0a got border=%b mic=%b ear=%b audio=%b exp 010/1/0/01",
                     border, mic, ear, audio);
        else pass_cnt++;
        repeat (2) cycle();
    endtask

    task automatic test_tape();
        tick_on = 1'b0;
        @(posedge clk);
        #3 tape_in = 1'b1;
        @(posedge clk);
        #1;
        total_cnt++;
        if (ear_in !== 1'b0) $display("FAIL tape_early ear_in got=%b exp=0", ear_in);
        else pass_cnt++;
        @(posedge clk);
        #1;
        total_cnt++;
        if ({ear_in, int_n, border} !== {1'b1, 1'b1, 3'b010})
            $display("FAIL tape_rise got ear_in=%b int_n=%b border=%b exp 1/1/010",
                     ear_in, int_n, border);
        else pass_cnt++;
        #12 tape_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total_cnt++;
        if ({ear_in, int_n, border} !== {1'b0, 1'b1, 3'b010})
            $display("FAIL tape_fall got ear_in=%b int_n=%b border=%b exp 0/1/010",
                     ear_in, int_n, border);
        else pass_cnt++;
        tick_on = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_flash();
        logic [4:0] exp_cnt;
        logic       exp_flash;
        reset = 1'b1;
        #1;
        @(negedge clk);
        reset = 1'b0;
        repeat (4) cycle();
        total_cnt++;
        if ({flash, frame_cnt} !== 6'd0) $display("FAIL flash_start got flash=%b cnt=%0d exp 0/0", flash, frame_cnt);
        else pass_cnt++;
        for (int i = 1; i <= 32; i++) begin
            vsync = 1'b0;
            repeat (3) cycle();
            vsync = 1'b1;
            repeat (5) cycle();
            exp_cnt   = 5'(i);
            exp_flash = ((i % 32) >= 16);
            total_cnt++;
            if ({flash, frame_cnt} !== {exp_flash, exp_cnt})
                $display("FAIL flash_frame_%0d got flash=%b cnt=%0d exp %b/%0d",
                         i, flash, frame_cnt, exp_flash, exp_cnt);
            else pass_cnt++;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        cpu_tick  = 1'b0;
        vsync     = 1'b1;
        n_ioWR    = 1'b1;
        cpu_addr0 = 1'b0;
        cpu_dout  = 8'h00;
        tape_in   = 1'b0;
        test_reset();
        test_int_pulse();
        test_retrigger();
        test_coincident();
        test_port_write();
        test_tape();
        test_flash();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
